maxterm_extractor: RTL and testbench

Sequential truth-table scanner: the inverse of our maxterm-expression blocks. Given a combinational function of N_VARS inputs, it sweeps every input combination, samples the function output and returns its maxterm list (bit mask of indices where F=0) plus the maxterm count. It is used as a self-checking companion to the guide exercises, wired between a stimulus controller and the function under test.

---
 rtl/maxterm_pkg.sv | 24 ++
 rtl/maxterm_extractor.sv | 104 ++++++++++
 tb/tb_maxterm_extractor.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/maxterm_pkg.sv
// Shared types and sizing helpers for the maxterm extractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package maxterm_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Truth-table size for a function of n inputs
  function automatic int table_size(input int n);
    return 1 << n;
  endfunction

  // Count width: one extra bit so a table with every entry zero (count = T) never wraps
  function automatic int count_width(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/maxterm_extractor.sv
// Sweeps all 2^N_VARS input combinations of a function under test and returns its maxterm mask and count.
// Latency: 2 cycles per table index (DRIVE then SAMPLE); done pulses the cycle after edge 2T.
// Backpressure: none; start is accepted only in IDLE, ignored otherwise. Optional abort port under MAXTERM_ABORT_EN.
module maxterm_extractor
  import maxterm_pkg::*;
#(
  parameter int N_VARS = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               f_in,
`ifdef MAXTERM_ABORT_EN
  input  logic                               abort,
`endif
  output logic [N_VARS-1:0]                  drive,
  output logic                               busy,
  output logic                               done,
  output logic [table_size(N_VARS)-1:0]      maxterm_mask,
  output logic [count_width(N_VARS)-1:0]     maxterm_count
);

  localparam int T     = table_size(N_VARS);
  localparam int CNT_W = count_width(N_VARS);

  state_t              state;
  state_t              state_nxt;
  logic [N_VARS-1:0]   idx;
  logic                last_idx;
  logic                abort_req;

  assign last_idx = (idx == N_VARS'(T - 1));

  // An abort only matters while a sweep is in flight; in IDLE and DONE it is ignored
`ifdef MAXTERM_ABORT_EN
  assign abort_req = abort && ((state == DRIVE) || (state == SAMPLE));
`else
  assign abort_req = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: abort beats the normal DRIVE/SAMPLE progression
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = abort_req ? IDLE : SAMPLE;
      SAMPLE: begin
        if (abort_req)     state_nxt = IDLE;
        else if (last_idx) state_nxt = DONE;
        else               state_nxt = DRIVE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; drive is the registered index, held for both cycles of a step
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    drive = '0;
    case (state)
      DRIVE, SAMPLE: begin
        busy  = 1'b1;
        drive = idx;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Index counter and result accumulation; results persist until the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      maxterm_mask  <= '0;
      maxterm_count <= '0;
    end else if (abort_req) begin
      idx           <= '0;
      maxterm_mask  <= '0;
      maxterm_count <= '0;
    end else if ((state == IDLE) && start) begin
      idx           <= '0;
      maxterm_mask  <= '0;
      maxterm_count <= '0;
    end else if (state == SAMPLE) begin
      maxterm_mask[idx] <= ~f_in;
      maxterm_count     <= maxterm_count + CNT_W'(~f_in);
      if (!last_idx) begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_maxterm_extractor.sv
// Self-checking bench for maxterm_extractor (N_VARS = 3), directed plus randomized truth tables.
// Latency: checks drive/busy/done cycle by cycle against edge numbering from the start edge.
// Backpressure: exercises ignored start pulses, async reset mid-sweep and abort when MAXTERM_ABORT_EN is set.
module tb_maxterm_extractor;

  localparam int N = 3;
  localparam int T = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           f_in;
  logic [N-1:0]   drive;
  logic           busy;
  logic           done;
  logic [T-1:0]   maxterm_mask;
  logic [N:0]     maxterm_count;
`ifdef MAXTERM_ABORT_EN
  logic           abort = 1'b0;
`endif

  // Truth table of the function under test: F(i) = f_tbl[i]
  logic [T-1:0]   f_tbl = '1;

  int checks   = 0;
  int failures = 0;

  assign f_in = f_tbl[drive];

  always #5 clk = ~clk;

  maxterm_extractor #(.N_VARS(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .f_in          (f_in),
`ifdef MAXTERM_ABORT_EN
    .abort         (abort),
`endif
    .drive         (drive),
    .busy          (busy),
    .done          (done),
    .maxterm_mask  (maxterm_mask),
    .maxterm_count (maxterm_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: maxterms are the table indices where the function is 0
  function automatic void model(input logic [T-1:0] tbl, output logic [T-1:0] m, output int c);
    m = '0;
    c = 0;
    for (int i = 0; i < T; i++) begin
      if (tbl[i] == 1'b0) begin
        m[i] = 1'b1;
        c++;
      end
    end
  endfunction

  // One full sweep; st_edges[k] = 1 holds start high across edge k (k >= 1)
  task automatic sweep(input string tag, input logic [T-1:0] tbl, input logic [31:0] st_edges);
    logic [T-1:0] em;
    int           ec;
    int           dones;
    dones = 0;
    model(tbl, em, ec);
    f_tbl = tbl;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int e = 0; e <= 2*T + 3; e++) begin
      #1;
      start = st_edges[e+1];
      @(negedge clk);
      if (done) dones++;
      if (e == 0) begin
        check($sformatf("%s mask_clr", tag), maxterm_mask, 0);
        check($sformatf("%s cnt_clr", tag), maxterm_count, 0);
      end
      if (e < 2*T) begin
        check($sformatf("%s busy e%0d", tag, e), busy, 1);
        check($sformatf("%s drive e%0d", tag, e), drive, e / 2);
        check($sformatf("%s done e%0d", tag, e), done, 0);
      end else if (e == 2*T) begin
        check($sformatf("%s done_pulse", tag), done, 1);
        check($sformatf("%s busy_end", tag), busy, 0);
        check($sformatf("%s drive_end", tag), drive, 0);
        check($sformatf("%s mask", tag), maxterm_mask, em);
        check($sformatf("%s count", tag), maxterm_count, ec);
      end else begin
        check($sformatf("%s idle_busy e%0d", tag, e), busy, 0);
        check($sformatf("%s idle_done e%0d", tag, e), done, 0);
      end
      @(posedge clk);
    end
    start = 1'b0;
    #1;
    check($sformatf("%s mask_hold", tag), maxterm_mask, em);
    check($sformatf("%s count_hold", tag), maxterm_count, ec);
    check($sformatf("%s done_once", tag), dones, 1);
  endtask

  initial begin
    logic [T-1:0] rt;
    logic [31:0]  rs;
    int           late_done;

    // Reset state
    #2;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst drive", drive, 0);
    check("rst mask", maxterm_mask, 0);
    check("rst count", maxterm_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // piM(1,5,7)
    sweep("pm157", ~8'hA2, 32'h0);
    check("pm157 spec_mask", maxterm_mask, 8'hA2);
    check("pm157 spec_cnt", maxterm_count, 3);

    // piM(0,4,6) then immediate rerun with piM(1,2,3,6)
    sweep("pm046", ~8'h51, 32'h0);
    check("pm046 spec_mask", maxterm_mask, 8'h51);
    sweep("pm1236", ~8'h4E, 32'h0);
    check("pm1236 spec_mask", maxterm_mask, 8'h4E);
    check("pm1236 spec_cnt", maxterm_count, 4);

    // Constant functions
    sweep("const1", 8'hFF, 32'h0);
    check("const1 spec_cnt", maxterm_count, 0);
    sweep("const0", 8'h00, 32'h0);
    check("const0 spec_cnt", maxterm_count, 8);

    // start re-presented at edges 3, 16 and 17 (the DONE cycle) must be ignored
    sweep("ignore", ~8'hA2, (32'd1 << 3) | (32'd1 << 16) | (32'd1 << 17));

    // Async reset at edge 7 of a piM(0,1,5,6) sweep
    f_tbl = ~8'h63;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid busy", busy, 1);
    check("mid mask_partial", maxterm_mask, 8'h03);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst busy", busy, 0);
    check("arst drive", drive, 0);
    check("arst done", done, 0);
    check("arst mask", maxterm_mask, 0);
    check("arst count", maxterm_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep("pm0156", ~8'h63, 32'h0);
    check("pm0156 spec_mask", maxterm_mask, 8'h63);
    check("pm0156 spec_cnt", maxterm_count, 4);

`ifdef MAXTERM_ABORT_EN
    // Abort at edge 5: back to IDLE, results cleared, no done pulse
    f_tbl = ~8'h95;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort mask", maxterm_mask, 0);
    check("abort count", maxterm_count, 0);
    late_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    check("abort quiet", late_done, 0);
    sweep("pm0247", ~8'h95, 32'h0);
    check("pm0247 spec_mask", maxterm_mask, 8'h95);
    check("pm0247 spec_cnt", maxterm_count, 4);
`else
    late_done = 0;
`endif

    // Randomized truth tables with stray start pulses inside the busy/done window
    for (int r = 0; r < 8; r++) begin
      rt = T'($urandom);
      rs = $urandom & 32'h0003_FFFE;
      sweep($sformatf("rand%0d", r), rt, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
